sqrt_fixed_point_seq: RTL and testbench
=======================================

SQRT_FIXED_POINT_SEQ -- requirements
Module: sqrt_fixed_point_seq

Interface
REQ-001 SHALL have parameter DATA_W, default 16: operand/result width, unsigned fixed point.
REQ-002 SHALL have parameter FRAC_W, default 8: fractional bits of operand and result; DATA_W+FRAC_W SHALL be even and FRAC_W < DATA_W.
REQ-003 SHALL have port i_clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_valid  input  1  operand valid.
REQ-006 SHALL have port o_ready  output  1  module can accept an operand.
REQ-007 SHALL have port i_data  input  DATA_W  operand, unsigned Q(DATA_W-FRAC_W).FRAC_W.
REQ-008 SHALL have port o_valid  output  1  result valid.
REQ-009 SHALL have port i_ready  input  1  downstream accepts result.
REQ-010 SHALL have port o_data  output  DATA_W  result, same Q format as i_data.

Function
REQ-011 SHALL compute o_data = floor(sqrt(i_data * 2^FRAC_W)), i.e. the square root in the same Q format, zero-extended to DATA_W.
REQ-012 SHALL use digit-by-digit (non-restoring) square root, one result bit per clock, with N = (DATA_W+FRAC_W)/2 iterations; remainder width N+2 bits.
REQ-013 SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 IDLE: o_ready=1; on i_valid&&o_ready, latch i_data, clear root and remainder, load the iteration counter with N-1, go to CALC.
REQ-015 CALC: o_ready=0, o_valid=0; one iteration per cycle; at counter==0 go to DONE.
REQ-016 DONE: o_valid=1, o_data stable; on i_ready go to IDLE; without i_ready, hold DONE and o_data indefinitely.
REQ-017 Latency SHALL be exactly N clocks from the accepting edge to the first edge with o_valid=1 (12 for the defaults).
REQ-018 i_valid during CALC or DONE SHALL be ignored, with no operand latched.
REQ-019 o_valid and o_ready SHALL never be high together; no new operand is accepted in the cycle a result is consumed.
REQ-020 i_data=0 SHALL yield 0; the all-ones operand SHALL not overflow (the root fits in N < DATA_W bits).

Reset
REQ-021 i_reset high SHALL immediately force state IDLE, o_ready=1 (combinational from state), o_valid=0, o_data=0, remainder/root/counter=0.
REQ-022 Reset during CALC or DONE SHALL abort the operation and discard the result; the first operand after reset deassertion SHALL compute normally.

Configuration
REQ-023 Macro SQRT_ROUND_EN defined: the result SHALL be rounded to nearest; if the final remainder > final root, output root+1 (fits since N < DATA_W); latency unchanged.
REQ-024 Macro SQRT_ROUND_EN undefined: the result SHALL be truncated per REQ-011, with no rounding logic present.

Structure
REQ-025 A shared package sqrt_pkg SHALL hold the FSM state enum (IDLE, CALC, DONE) and a function deriving N from DATA_W and FRAC_W.
REQ-026 A sub-module sqrt_step SHALL be instantiated: combinational single iteration (remainder, root, next two operand bits in; new remainder and root bit out).
REQ-027 Total RTL SHALL be 120-400 lines.

Verification (DATA_W=16, FRAC_W=8)
REQ-028 Scenario: reset, then i_data=0x0400 (4.0) -> o_valid exactly 12 clocks after accept, o_data=0x0200.
REQ-029 Scenario: i_data=0x0200 (2.0) -> o_data=0x016A in both builds.
REQ-030 Scenario: i_data=0xFFFF -> o_data=0x0FFF without SQRT_ROUND_EN, 0x1000 with it.
REQ-031 Scenario: i_data=0x0000 -> 0x0000; i_data=0x0100 -> 0x0100.
REQ-032 Scenario: hold i_ready=0 for 20 clocks in DONE while toggling i_valid/i_data -> o_data and o_valid stable, o_ready=0, no new operand accepted.
REQ-033 Scenario: assert i_reset at CALC cycle 5 -> o_valid=0 and o_data=0 immediately, o_ready=1; next operand 0x0900 -> 0x0300 after 12 clocks.

Source files
------------

// File: rtl/sqrt_pkg.sv
// Shared definitions for the sequential fixed-point square root:
// FSM state encoding and the iteration-count helper.
package sqrt_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } sqrt_state_e;

   // One result bit per iteration; the radicand has DATA_W+FRAC_W bits,
   // consumed two at a time.
   function automatic int sqrt_iters(input int data_w, input int frac_w);
      return (data_w + frac_w) / 2;
   endfunction

endpackage

// File: rtl/sqrt_step.sv
// One combinational iteration of the non-restoring digit-by-digit square root.
// Takes the signed partial remainder, the root so far and the next two
// radicand bits, and produces the new remainder and the new root bit.
module sqrt_step
#(
   parameter int N = 12
)
(
   input  logic [N+1:0] rem_in,
   input  logic [N-1:0] root_in,
   input  logic [1:0]   bits_in,
   output logic [N+1:0] rem_out,
   output logic         root_bit
);

   logic [N+1:0] rem_shift;

   // A non-negative remainder subtracts 4q+1, a negative one adds 4q+3;
   // the sign of the result gives the next root bit. Wrap-around in the
   // shift is harmless because the final value always fits in N+2 bits.
   always_comb begin
      rem_shift = (rem_in << 2) | {{N{1'b0}}, bits_in};
      if (rem_in[N+1]) begin
         rem_out = rem_shift + {root_in, 2'b11};
      end else begin
         rem_out = rem_shift - {root_in, 2'b01};
      end
      root_bit = ~rem_out[N+1];
   end

endmodule

// File: rtl/sqrt_fixed_point_seq.sv
// Sequential unsigned fixed-point square root, one result bit per clock.
// Result is floor(sqrt(i_data * 2^FRAC_W)) in the same Q format as i_data.
// Optional macro SQRT_ROUND_EN rounds the result to nearest instead of
// truncating; latency is unchanged either way.
module sqrt_fixed_point_seq
   import sqrt_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 8
)
(
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [DATA_W-1:0] i_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [DATA_W-1:0] o_data
);

   localparam int N  = sqrt_iters(DATA_W, FRAC_W);
   localparam int RW = N + 2;
   localparam int SW = 2 * N;
   localparam int CW = $clog2(N + 1);

   sqrt_state_e       state;
   sqrt_state_e       state_next;
   logic [SW-1:0]     radicand;
   logic [RW-1:0]     rem;
   logic [N-1:0]      root;
   logic [CW-1:0]     count;
   logic [DATA_W-1:0] result;

   logic              accept;
   logic              last_iter;
   logic [RW-1:0]     step_rem;
   logic              step_bit;
   logic [N-1:0]      root_next;
   logic [DATA_W-1:0] final_result;

   sqrt_step #(.N(N)) u_step (
      .rem_in   (rem),
      .root_in  (root),
      .bits_in  (radicand[SW-1 -: 2]),
      .rem_out  (step_rem),
      .root_bit (step_bit)
   );

   assign root_next = {root[N-2:0], step_bit};

`ifdef SQRT_ROUND_EN
   logic [RW-1:0] fixed_rem;
   logic          round_up;

   // Restore a negative final remainder, then round up when the remainder
   // exceeds the root, i.e. when the radicand lies above (root+0.5)^2.
   always_comb begin
      fixed_rem = step_rem;
      if (step_rem[RW-1]) begin
         fixed_rem = step_rem + {1'b0, root_next, 1'b1};
      end
      round_up     = (fixed_rem > {2'b00, root_next});
      final_result = DATA_W'(root_next) + DATA_W'(round_up);
   end
`else
   // Truncating build: the root is the result, zero-extended.
   assign final_result = DATA_W'(root_next);
`endif

   // State register; reset aborts any operation in flight.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and handshake outputs, decoded purely from the state.
   always_comb begin
      state_next = state;
      o_ready    = 1'b0;
      o_valid    = 1'b0;
      accept     = 1'b0;
      last_iter  = (count == '0);
      case (state)
         IDLE: begin
            o_ready = 1'b1;
            accept  = i_valid;
            if (i_valid) begin
               state_next = CALC;
            end
         end
         CALC: begin
            if (last_iter) begin
               state_next = DONE;
            end
         end
         DONE: begin
            o_valid = 1'b1;
            if (i_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: load the operand on accept, iterate once per CALC cycle and
   // capture the result on the last iteration so it stays put through DONE.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         radicand <= '0;
         rem      <= '0;
         root     <= '0;
         count    <= '0;
         result   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  radicand <= {i_data, {FRAC_W{1'b0}}};
                  rem      <= '0;
                  root     <= '0;
                  count    <= CW'(N - 1);
               end
            end
            CALC: begin
               radicand <= radicand << 2;
               rem      <= step_rem;
               root     <= root_next;
               if (last_iter) begin
                  result <= final_result;
               end else begin
                  count <= count - CW'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign o_data = result;

endmodule

// File: tb/tb_sqrt_fixed_point_seq.sv
// Self-checking bench for sqrt_fixed_point_seq (DATA_W=16, FRAC_W=8).
// Expected values follow SQRT_ROUND_EN when the build defines it.
module tb_sqrt_fixed_point_seq;

   localparam int DATA_W  = 16;
   localparam int FRAC_W  = 8;
   localparam int LATENCY = 12;

   logic              i_clk = 1'b0;
   logic              i_reset;
   logic              i_valid;
   logic              o_ready;
   logic [DATA_W-1:0] i_data;
   logic              o_valid;
   logic              i_ready;
   logic [DATA_W-1:0] o_data;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic [DATA_W-1:0] exp_trunc;
      logic [DATA_W-1:0] exp_round;
      string             name;
   } vec_t;

   vec_t vecs[9];

   sqrt_fixed_point_seq #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) dut (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_data  (i_data),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_data  (o_data)
   );

   // Free-running 100 MHz clock.
   always #5 i_clk = ~i_clk;

   function automatic logic [DATA_W-1:0] pick(input vec_t v);
`ifdef SQRT_ROUND_EN
      return v.exp_round;
`else
      return v.exp_trunc;
`endif
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Accept one operand and wait (bounded) for its result; checks the
   // handshake, the latency and the result. Leaves the DUT in DONE.
   task automatic applyStimulus(input logic [DATA_W-1:0] data,
                                input logic [DATA_W-1:0] expected,
                                input string name);
      int cycles;
      @(negedge i_clk);
      checkOutput({name, " ready before accept"}, 32'(o_ready), 32'd1);
      i_valid = 1'b1;
      i_data  = data;
      i_ready = 1'b0;
      @(posedge i_clk);
      @(negedge i_clk);
      i_valid = 1'b0;
      i_data  = ~data;
      checkOutput({name, " busy after accept"}, 32'(o_ready), 32'd0);
      cycles = 0;
      while (!o_valid && cycles < 40) begin
         @(negedge i_clk);
         cycles++;
      end
      checkOutput({name, " latency"}, 32'(cycles), 32'(LATENCY));
      checkOutput({name, " result"}, 32'(o_data), 32'(expected));
   endtask

   // Consume the pending result, keeping i_valid high through the consume
   // edge to show no operand is taken in that same cycle.
   task automatic consumeResult(input string name);
      @(negedge i_clk);
      i_ready = 1'b1;
      i_valid = 1'b1;
      i_data  = 16'h0100;
      @(posedge i_clk);
      @(negedge i_clk);
      i_ready = 1'b0;
      i_valid = 1'b0;
      checkOutput({name, " valid after consume"}, 32'(o_valid), 32'd0);
      checkOutput({name, " ready after consume"}, 32'(o_ready), 32'd1);
   endtask

   initial begin
      logic [DATA_W-1:0] held;

      vecs[0] = '{16'h0400, 16'h0200, 16'h0200, "sqrt4"};
      vecs[1] = '{16'h0200, 16'h016A, 16'h016A, "sqrt2"};
      vecs[2] = '{16'hFFFF, 16'h0FFF, 16'h1000, "allones"};
      vecs[3] = '{16'h0000, 16'h0000, 16'h0000, "zero"};
      vecs[4] = '{16'h0100, 16'h0100, 16'h0100, "one"};
      vecs[5] = '{16'h0002, 16'h0016, 16'h0017, "tiny"};
      vecs[6] = '{16'h0190, 16'h0140, 16'h0140, "1p5625"};
      vecs[7] = '{16'h7FFF, 16'h0B50, 16'h0B50, "7fff"};
      vecs[8] = '{16'h0900, 16'h0300, 16'h0300, "sqrt9"};

      i_reset = 1'b1;
      i_valid = 1'b0;
      i_ready = 1'b0;
      i_data  = '0;
      repeat (2) @(negedge i_clk);
      checkOutput("reset ready", 32'(o_ready), 32'd1);
      checkOutput("reset valid", 32'(o_valid), 32'd0);
      checkOutput("reset data", 32'(o_data), 32'd0);
      i_reset = 1'b0;

      // First operand straight after reset, then hold the result in DONE
      // while the input side is noisy.
      applyStimulus(16'h0400, 16'h0200, "first");
      held = o_data;
      for (int i = 0; i < 20; i++) begin
         @(negedge i_clk);
         i_valid = i[0];
         i_data  = 16'($urandom);
         checkOutput("hold valid", 32'(o_valid), 32'd1);
         checkOutput("hold ready", 32'(o_ready), 32'd0);
         checkOutput("hold data", 32'(o_data), 32'(held));
      end
      i_valid = 1'b0;
      consumeResult("hold");

      for (int k = 0; k < 9; k++) begin
         applyStimulus(vecs[k].data, pick(vecs[k]), vecs[k].name);
         consumeResult(vecs[k].name);
      end

      // Reset in the middle of a calculation.
      @(negedge i_clk);
      i_valid = 1'b1;
      i_data  = 16'h0400;
      @(posedge i_clk);
      @(negedge i_clk);
      i_valid = 1'b0;
      repeat (5) @(posedge i_clk);
      @(negedge i_clk);
      i_reset = 1'b1;
      #1;
      checkOutput("calc reset valid", 32'(o_valid), 32'd0);
      checkOutput("calc reset data", 32'(o_data), 32'd0);
      checkOutput("calc reset ready", 32'(o_ready), 32'd1);
      @(negedge i_clk);
      i_reset = 1'b0;
      applyStimulus(16'h0900, 16'h0300, "after calc reset");

      // Reset while a result is waiting in DONE.
      @(negedge i_clk);
      i_reset = 1'b1;
      #1;
      checkOutput("done reset valid", 32'(o_valid), 32'd0);
      checkOutput("done reset data", 32'(o_data), 32'd0);
      checkOutput("done reset ready", 32'(o_ready), 32'd1);
      @(negedge i_clk);
      i_reset = 1'b0;
      applyStimulus(16'h0100, 16'h0100, "after done reset");
      consumeResult("after done reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
